demux1to4_router: RTL
=====================

Name: demux1to4_router

Overview:
- Fan-out counterpart to the datapath's 4:1 select mux: steers one valid/ready input stream to one of four output channels, chosen per beat by a 2-bit select.
- Each channel has its own small FIFO, so a stalled consumer blocks only beats addressed to it.
- Sits between a single producer (e.g. writeback/result bus) and four independent consumers.

Parameters:
- W, 32, data width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  producer has a beat
- in_ready  out  1  router accepts the beat this cycle
- in_select  in  2  destination channel: 2'b00..2'b11 map to channel 0..3
- in_data  in  W  beat payload
- out_valid  out  4  bit k: channel k head entry valid
- out_ready  in  4  bit k: consumer k takes the head entry
- out_data0 / out_data1 / out_data2 / out_data3  out  W each  channel 0..3 head payload
- ch_count  out  4*($clog2(DEPTH)+1)  per-channel occupancy; channel k in slice k

Behaviour:
- Accept: a beat is accepted when in_valid && in_ready at the clk edge.
  - in_ready = !full[in_select]. It depends only on in_select and registered state, never on out_ready.
  - in_select and in_data are sampled only on the accept edge.
  - When in_valid = 0, in_ready still reflects the selected channel.
- Latency: an accepted beat is visible on out_valid[k] and out_data<k> starting the cycle after the accept edge. No combinational bypass.
- Pop: channel k pops its head when out_valid[k] && out_ready[k] at the edge.
  - out_data<k> then shows the next entry on the following cycle, or holds its last value with out_valid[k] = 0 if the channel is empty.
- Ordering:
  - Beats to the same channel are delivered in acceptance order.
  - No ordering is implied across channels.
- Simultaneous push and pop on the same channel:
  - Allowed whenever the channel is not full; count is unchanged.
  - When the channel is full, in_ready = 0, so no push occurs even if a pop happens in the same cycle. The freed slot becomes available the next cycle.
- Full/empty:
  - Push when full is impossible by construction.
  - Pop when empty is ignored, because out_valid[k] = 0.
  - Pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Channels are independent. Pops on any subset of channels may coincide with a push to any channel.
- Reset:
  - All counts = 0, pointers = 0, out_valid = 4'b0000, all out_data = 0, ch_count = 0.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset asserted mid-stream discards all stored beats. An accept coincident with the reset edge is dropped.
- Protocol assumption on the producer: once in_valid is high, in_valid, in_select and in_data stay stable until accepted. The bench checks this with an assertion.
- There is no state machine beyond the per-channel FIFO pointers and counters.

Decomposition:
- Shared include file holds:
  - channel select encodings CH0..CH3 (2'b00..2'b11);
  - default DEPTH;
  - the count-width macro $clog2(DEPTH)+1.
- Natural sub-module: demux_fifo, a parameterised W × DEPTH synchronous FIFO.
  - Interface: push/push_data/full, pop/head_data/empty, count.
  - demux1to4_router instantiates it four times.
  - Top-level logic is limited to select decoding (push fan-out) and in_ready selection, the inverse of the mux's select.

Test Plan:
- Reset then idle: assert reset 2 cycles, release → out_valid = 0000, ch_count all 0, in_ready = 1, all out_data = 0.
- Routing: one beat each, sel 0..3 with data 0xA0, 0xB1, 0xC2, 0xD3, out_ready = 1111 → each appears exactly once on its channel one cycle after accept; other channels stay invalid.
- Backpressure: out_ready[2] = 0, push 3 beats to ch2 (0x11, 0x22, 0x33) → first two accepted, in_ready = 0 for the third while sel = 2, ch_count[2] = 2.
  - A sel = 1 beat 0x44 issued meanwhile is accepted immediately.
  - Raise out_ready[2] → 0x11 then 0x22 delivered, then 0x33 accepted the cycle after the first pop.
- Simultaneous push/pop: ch0 holding 1 entry, push 0x55 while popping → count stays 1, head becomes 0x55 next cycle.
- Wrap-around: stream 10 beats 0x01..0x0A to ch3 with out_ready[3] toggling each cycle → output order 0x01..0x0A exactly, no loss or duplication, count never exceeds DEPTH.
- Reset mid-operation: ch1 holding 2 entries, ch0 holding 1, assert reset one cycle → all out_valid = 0, counts = 0; a subsequent ch1 beat 0x77 is delivered as the sole entry.

Source files
------------

// File: rtl/demux1to4_router_pkg.sv
// ============================================================================
// Module      : demux1to4_router_pkg
// Description : Shared channel encodings and sizing helpers for the 1:4 router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package demux1to4_router_pkg;

  localparam logic [1:0] CH0 = 2'b00;
  localparam logic [1:0] CH1 = 2'b01;
  localparam logic [1:0] CH2 = 2'b10;
  localparam logic [1:0] CH3 = 2'b11;

  localparam int DEFAULT_DEPTH = 2;

  // Occupancy runs 0..DEPTH inclusive, hence one bit more than the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/demux_fifo.sv
// ============================================================================
// Module      : demux_fifo
// Description : W x DEPTH synchronous FIFO with a registered-state head view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux_fifo
  import demux1to4_router_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW   = count_width(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  output logic          full,
  input  logic          pop,
  output logic [W-1:0]  head_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int c_ptr_w = $clog2(DEPTH);

  logic [W-1:0]       r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [CW-1:0]      r_count;
  logic [W-1:0]       r_last;
  logic               w_do_push;
  logic               w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // When drained, keep showing the last delivered word rather than a stale slot.
  assign head_data = empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset && w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_last   <= r_mem[r_rd_ptr];
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux1to4_router.sv
// ============================================================================
// Module      : demux1to4_router
// Description : Steers one valid/ready stream to one of four buffered channels.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1to4_router
  import demux1to4_router_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int CW   = count_width(DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_select,
  input  logic [W-1:0]    in_data,
  output logic [3:0]      out_valid,
  input  logic [3:0]      out_ready,
  output logic [W-1:0]    out_data0,
  output logic [W-1:0]    out_data1,
  output logic [W-1:0]    out_data2,
  output logic [W-1:0]    out_data3,
  output logic [4*CW-1:0] ch_count
);

  logic [3:0]   w_sel_onehot;
  logic [3:0]   w_full;
  logic [3:0]   w_empty;
  logic [W-1:0] w_head [4];
  logic         w_accept;

  always_comb begin
    w_sel_onehot = 4'b0000;
    case (in_select)
      CH0:     w_sel_onehot = 4'b0001;
      CH1:     w_sel_onehot = 4'b0010;
      CH2:     w_sel_onehot = 4'b0100;
      CH3:     w_sel_onehot = 4'b1000;
      default: w_sel_onehot = 4'b0000;
    endcase
  end

  // Ready depends only on the addressed channel, never on any out_ready.
  assign in_ready = !w_full[in_select];
  assign w_accept = in_valid && in_ready;

  generate
    for (genvar k = 0; k < 4; k++) begin : g_ch
      demux_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (w_accept && w_sel_onehot[k]),
        .push_data (in_data),
        .full      (w_full[k]),
        .pop       (out_ready[k]),
        .head_data (w_head[k]),
        .empty     (w_empty[k]),
        .count     (ch_count[k*CW +: CW])
      );
    end
  endgenerate

  assign out_valid = ~w_empty;
  assign out_data0 = w_head[0];
  assign out_data1 = w_head[1];
  assign out_data2 = w_head[2];
  assign out_data3 = w_head[3];

endmodule

`default_nettype wire
